// File: rtl/wb_cmd_master.sv
// Wishbone B3 classic single-transfer master: one command in, one bus cycle, one response out.
// Optional ack timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i
);

    if (DAT_W != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("wb_cmd_master: DAT_W must be 32 and TIMEOUT_CYCLES within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state;
    logic   timeout_hit;
    logic   bus_done;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    // Ack has priority: a timeout only fires on an edge where ack is low.
    assign timeout_hit = (to_cnt == TO_LAST) && !wbm_ack_i;
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus_done = wbm_ack_i || timeout_hit;

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, and every register
        // here (datapath included) has a defined reset value because all outputs are registered.
        if (wb_rst_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        state       <= BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        // Address and byte select keep their last value; data and we park at 0.
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_dat_o   <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= timeout_hit;
                        if (timeout_hit) begin
                            rsp_dat_o <= '1;
                        end else if (wbm_we_o) begin
                            rsp_dat_o <= '0;
                        end else begin
                            rsp_dat_o <= wbm_dat_i;
                        end
                        state <= RESP;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the command/bus/response rules.
module tb_wb_cmd_master;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int TO    = 4;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             wb_clk_i;
    logic             wb_rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [DAT_W-1:0] cmd_dat_i;
    logic [3:0]       cmd_sel_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic [DAT_W-1:0] wbm_dat_i;
    logic             wbm_ack_i;

    wb_cmd_master #(
        .ADR_W         (ADR_W),
        .DAT_W         (DAT_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .cmd_sel_i  (cmd_sel_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // One command plus how the bench's slave and consumer treat it.
    // ack_at: bus cycle (1-based) in which the slave acks, 0 = never.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdat;
        int          ack_at;
        int          ready_wait;
        int          gap;
    } cmd_t;

    cmd_t        cmd_q[$];
    cmd_t        cur;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    // Transaction-level model state.
    bit          m_busy;
    bit          m_in_bus;
    int          m_bus_k;
    int          m_resp_k;
    int          m_idx;
    int          m_gap;
    logic [31:0] m_rsp_dat;
    logic        m_rsp_err;
    logic [31:0] m_last_adr;
    logic [3:0]  m_last_sel;
    bit          spur_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_in_bus   = 1'b0;
        m_bus_k    = 0;
        m_resp_k   = 0;
        m_last_adr = '0;
        m_last_sel = '0;
    endtask

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] rdat,
                        input int ack_at, input int ready_wait, input int gap);
        cmd_t c;
        c.we = we; c.adr = adr; c.dat = dat; c.sel = sel; c.rdat = rdat;
        c.ack_at = ack_at; c.ready_wait = ready_wait; c.gap = gap;
        cmd_q.push_back(c);
    endtask

    task automatic check_outputs(input string name);
        check({name, ".cmd_ready"}, 32'(cmd_ready_o), 32'(!m_busy));
        check({name, ".cyc"}, 32'(wbm_cyc_o), 32'(m_in_bus));
        check({name, ".stb"}, 32'(wbm_stb_o), 32'(m_in_bus));
        check({name, ".adr"}, wbm_adr_o, m_last_adr);
        check({name, ".sel"}, 32'(wbm_sel_o), 32'(m_last_sel));
        if (m_in_bus) begin
            check({name, ".we"}, 32'(wbm_we_o), 32'(cur.we));
            check({name, ".wdat"}, wbm_dat_o, cur.dat);
        end else begin
            check({name, ".we_idle"}, 32'(wbm_we_o), 32'd0);
            check({name, ".wdat_idle"}, wbm_dat_o, 32'd0);
        end
        check({name, ".rsp_valid"}, 32'(rsp_valid_o), 32'(m_busy && !m_in_bus));
        if (m_busy && !m_in_bus) begin
            check({name, ".rsp_dat"}, rsp_dat_o, m_rsp_dat);
            check({name, ".rsp_err"}, 32'(rsp_err_o), 32'(m_rsp_err));
        end
    endtask

    // Plays producer, slave and consumer for everything in cmd_q, checking each cycle.
    task automatic run_queue(input string name);
        int          cycles;
        bit          acc, hs, d_ack, d_to;
        logic [31:0] sdat;
        cycles = 0;
        m_idx  = 0;
        m_gap  = 0;
        while ((m_idx < cmd_q.size() || m_busy) && cycles < 3000) begin
            if (m_idx < cmd_q.size() && m_gap >= cmd_q[m_idx].gap) begin
                cmd_valid_i = 1'b1;
                cmd_we_i    = cmd_q[m_idx].we;
                cmd_adr_i   = cmd_q[m_idx].adr;
                cmd_dat_i   = cmd_q[m_idx].dat;
                cmd_sel_i   = cmd_q[m_idx].sel;
            end else begin
                cmd_valid_i = 1'b0;
                cmd_adr_i   = $urandom();
            end
            if (m_in_bus) wbm_ack_i = (m_bus_k == cur.ack_at);
            else          wbm_ack_i = spur_en && ($urandom_range(3) == 0);
            wbm_dat_i = (m_in_bus && wbm_ack_i) ? cur.rdat : $urandom();
            if (m_busy && !m_in_bus) rsp_ready_i = (m_resp_k >= cur.ready_wait);
            else                     rsp_ready_i = 1'($urandom_range(1));

            acc   = cmd_valid_i && !m_busy;
            hs    = m_busy && !m_in_bus && rsp_ready_i;
            d_ack = m_in_bus && wbm_ack_i;
            d_to  = m_in_bus && !wbm_ack_i && TO_EN && (m_bus_k == TO);
            sdat  = wbm_dat_i;

            tick();
            cycles++;
            m_gap++;

            if (hs) m_busy = 1'b0;
            else if (m_busy && !m_in_bus) m_resp_k++;
            if (d_ack) begin
                m_in_bus  = 1'b0;
                m_rsp_dat = cur.we ? 32'd0 : sdat;
                m_rsp_err = 1'b0;
                m_resp_k  = 0;
            end else if (d_to) begin
                m_in_bus  = 1'b0;
                m_rsp_dat = 32'hFFFF_FFFF;
                m_rsp_err = 1'b1;
                m_resp_k  = 0;
            end else if (m_in_bus) begin
                m_bus_k++;
            end
            if (acc) begin
                cur        = cmd_q[m_idx];
                m_idx++;
                m_busy     = 1'b1;
                m_in_bus   = 1'b1;
                m_bus_k    = 1;
                m_gap      = 0;
                m_last_adr = cur.adr;
                m_last_sel = cur.sel;
            end
            check_outputs(name);
        end
        check({name, ".drained"}, 32'(m_idx == cmd_q.size() && !m_busy), 32'd1);
        cmd_valid_i = 1'b0;
        wbm_ack_i   = 1'b0;
        cmd_q.delete();
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = '0;
        wbm_ack_i   = 1'b0;
        spur_en     = 1'b0;
        model_reset();

        // Reset state.
        tick();
        tick();
        check_outputs("reset");
        check("reset.rsp_dat", rsp_dat_o, 32'd0);
        check("reset.rsp_err", 32'(rsp_err_o), 32'd0);
        wb_rst_i = 1'b0;

        // Write acked in the third bus cycle.
        push(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 32'h1111_2222, 3, 0, 0);
        run_queue("write");

        // Read acked in the first bus cycle, response held off 5 cycles while a
        // second command waits with cmd_valid held.
        push(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 5, 0);
        push(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'h3, 32'h0, 2, 0, 0);
        run_queue("read_bp");

        // Spurious ack while idle.
        wbm_ack_i = 1'b1;
        tick();
        tick();
        wbm_ack_i = 1'b0;
        check("spur.rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("spur.cyc", 32'(wbm_cyc_o), 32'd0);
        check("spur.cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Reset in the middle of a bus cycle.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h3000_0020;
        cmd_sel_i   = 4'h1;
        tick();
        cmd_valid_i = 1'b0;
        check("midrst.cyc_before", 32'(wbm_cyc_o), 32'd1);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i  = 1'b0;
        model_reset();
        check_outputs("midrst");
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        check("midrst.late_ack_rsp", 32'(rsp_valid_o), 32'd0);
        check("midrst.late_ack_ready", 32'(cmd_ready_o), 32'd1);

        // No ack at all (times out when the feature is built in), then ack on the 4th cycle.
        push(1'b0, 32'h3000_0030, 32'h0, 4'hF, 32'h1234_5678, TO_EN ? 0 : 12, 0, 0);
        push(1'b0, 32'h3000_0034, 32'h0, 4'hF, 32'hCAFE_0004, 4, 1, 1);
        run_queue("timeout");

        // Three queued commands, cmd_valid held throughout.
        push(1'b1, 32'h3000_0100, 32'h0000_0001, 4'h1, 32'h0, 1, 0, 0);
        push(1'b0, 32'h3000_0104, 32'h0,         4'hC, 32'h5555_AAAA, 2, 0, 0);
        push(1'b1, 32'h3000_0108, 32'h0000_0003, 4'h8, 32'h0, 1, 0, 0);
        run_queue("b2b");

        // Randomized traffic with spurious acks between transactions.
        spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(1'($urandom_range(1)), $urandom(), $urandom(), 4'($urandom_range(15)),
                 $urandom(), int'($urandom_range(6, 1)), int'($urandom_range(3)),
                 int'($urandom_range(2)));
        end
        run_queue("rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
